// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder
//   Purpose : responder end of the ibex data req/gnt/rvalid bus, backed by an
//             internal word-organised RAM with byte-enabled writes.
//   Latency : rvalid at least Latency cycles after the grant cycle, strictly in
//             grant order, at most one response per cycle.
//   Backpressure: grant withheld while gnt_stall_i is high or while
//             MaxOutstanding responses are queued; responses are never blocked.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   data_req_i        request valid
//   data_addr_i       byte address (bits [1:0] ignored)
//   data_we_i         1 = write, 0 = read
//   data_be_i         write byte enables
//   data_wdata_i      lane-aligned write data
//   gnt_stall_i       forces the grant low this cycle
//   data_gnt_o        request accepted this cycle
//   data_rvalid_o     response valid
//   data_rdata_o      read data (0 unless a valid in-range read response)
//   data_err_o        response is an address-range error (qualified by rvalid)
//   outstanding_o     granted, unanswered request count

module ibex_data_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        gnt_stall_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [2:0]  outstanding_o
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Address window size in bytes, one bit wider than the bus so the
    // comparison cannot wrap for large memories.
    localparam logic [32:0]   SpanBytes = 33'(MemWords) << 2;
    localparam logic [2:0]    PushDelay = 3'(Latency - 1);
    localparam logic [2:0]    MaxCnt    = 3'(MaxOutstanding);
    localparam logic [PW-1:0] LastPtr   = PW'(MaxOutstanding - 1);

    // One queued response. dly counts down to zero; the head entry is
    // presented on the bus once its dly reaches zero.
    typedef struct packed {
        logic        vld;
        logic [2:0]  dly;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   mem [MemWords];

    resp_t         resp_q [MaxOutstanding];
    resp_t         resp_d [MaxOutstanding];
    logic [PW-1:0] hd_q, hd_d;
    logic [PW-1:0] tl_q, tl_d;
    logic [2:0]    cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]   addr_off;
    logic          in_range;
    logic [AW-1:0] word_idx;

    // A single subtraction covers both bounds: addresses below BaseAddr
    // are rejected explicitly, the upper bound is checked on the offset.
    assign addr_off = data_addr_i - BaseAddr;
    assign in_range = (data_addr_i >= BaseAddr) && ({1'b0, addr_off} < SpanBytes);
    assign word_idx = addr_off[AW+1:2];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;
    logic push;
    logic pop;

    // The grant deliberately ignores a same-cycle pop: a full queue
    // withholds the grant for one cycle even if the head leaves now.
    assign data_gnt_o = data_req_i & ~gnt_stall_i & (cnt_q < MaxCnt);
    assign accept     = data_req_i & data_gnt_o;
    assign push       = accept;

    assign data_rvalid_o = resp_q[hd_q].vld && (resp_q[hd_q].dly == 3'd0);
    assign pop           = data_rvalid_o;

    // ------------------------------------------------------------------
    // RAM: not reset. Writes land at the accept edge, so any read accepted
    // on a later edge observes them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response payload captured at the accept edge. Writes and errors
    // carry zero data.
    logic [31:0] push_rdata;
    logic        push_err;

    always_comb begin
        push_rdata = 32'h0;
        push_err   = ~in_range;
        if (in_range && !data_we_i) begin
            push_rdata = mem[word_idx];
        end
    end

    // ------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        resp_d = resp_q;
        hd_d   = hd_q;
        tl_d   = tl_q;
        cnt_d  = cnt_q;

        // Age every queued entry; entries behind the head keep counting
        // so they can issue on consecutive cycles once the head drains.
        for (int i = 0; i < int'(MaxOutstanding); i++) begin
            if (resp_q[i].vld && (resp_q[i].dly != 3'd0)) begin
                resp_d[i].dly = resp_q[i].dly - 3'd1;
            end
        end

        if (pop) begin
            resp_d[hd_q].vld = 1'b0;
            hd_d             = ptr_inc(hd_q);
        end

        // The grant guarantees a free slot at tl_q whenever push is high,
        // and tl_q differs from hd_q whenever a pop happens alongside.
        if (push) begin
            resp_d[tl_q].vld   = 1'b1;
            resp_d[tl_q].dly   = PushDelay;
            resp_d[tl_q].err   = push_err;
            resp_d[tl_q].rdata = push_rdata;
            tl_d               = ptr_inc(tl_q);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                resp_q[i] <= '0;
            end
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= 3'd0;
        end else begin
            resp_q <= resp_d;
            hd_q   <= hd_d;
            tl_q   <= tl_d;
            cnt_q  <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_rdata_o  = data_rvalid_o ? resp_q[hd_q].rdata : 32'h0;
    assign data_err_o    = data_rvalid_o & resp_q[hd_q].err;
    assign outstanding_o = cnt_q;

`ifndef SYNTHESIS
    // Queue occupancy can never exceed its depth, and a push into a full
    // queue would overwrite an unanswered response.
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= MaxCnt);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (cnt_q == MaxCnt)));
    a_pop_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && (cnt_q == 3'd0)));
`endif

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Directed bench for ibex_data_mem_responder.
// Three instances share clock and reset: index 0 Latency=1, index 1
// Latency=4, index 2 Latency=3 (all MemWords=1024, MaxOutstanding=2).
module tb_ibex_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        stall [3];

    logic        gnt_o [3];
    logic        rv_o  [3];
    logic [31:0] rd_o  [3];
    logic        err_o [3];
    logic [2:0]  os_o  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ibex_data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(2)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[0]), .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]),
        .data_wdata_i(wdata[0]), .gnt_stall_i(stall[0]),
        .data_gnt_o(gnt_o[0]), .data_rvalid_o(rv_o[0]), .data_rdata_o(rd_o[0]),
        .data_err_o(err_o[0]), .outstanding_o(os_o[0]));

    ibex_data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(4), .MaxOutstanding(2)) u_dut_l4 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[1]), .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]),
        .data_wdata_i(wdata[1]), .gnt_stall_i(stall[1]),
        .data_gnt_o(gnt_o[1]), .data_rvalid_o(rv_o[1]), .data_rdata_o(rd_o[1]),
        .data_err_o(err_o[1]), .outstanding_o(os_o[1]));

    ibex_data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(2)) u_dut_l3 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[2]), .data_addr_i(addr[2]), .data_we_i(we[2]), .data_be_i(be[2]),
        .data_wdata_i(wdata[2]), .gnt_stall_i(stall[2]),
        .data_gnt_o(gnt_o[2]), .data_rvalid_o(rv_o[2]), .data_rdata_o(rd_o[2]),
        .data_err_o(err_o[2]), .outstanding_o(os_o[2]));

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[k] = r; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    endtask

    // Bounded single write used to preload the slower instances.
    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d);
        logic granted;
        granted = 1'b0;
        drive(k, 1'b1, 1'b1, a, 4'hF, d);
        for (int n = 0; n < 20 && !granted; n++) begin
            @(negedge clk);
            granted = (gnt_o[k] === 1'b1);
            next();
        end
        req[k] = 1'b0;
        total++;
        if (!granted) begin bad++; $display("FAIL preload_gnt[%0d]: no grant for addr %h within 20 cycles", k, a); end
    endtask

    task automatic drain(input int k);
        logic empty;
        empty = 1'b0;
        req[k] = 1'b0;
        for (int n = 0; n < 20 && !empty; n++) begin
            @(negedge clk);
            empty = (os_o[k] === 3'd0);
            if (!empty) next();
        end
        next();
        total++;
        if (!empty) begin bad++; $display("FAIL drain[%0d]: outstanding=%0d want 0 within 20 cycles", k, os_o[k]); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
            stall[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            total++; if (gnt_o[k] !== 1'b1) begin bad++; $display("FAIL reset_gnt[%0d]: got %b want 1", k, gnt_o[k]); end
            total++; if (rv_o[k] !== 1'b0) begin bad++; $display("FAIL reset_rvalid[%0d]: got %b want 0", k, rv_o[k]); end
            total++; if (rd_o[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rd_o[k]); end
            total++; if (err_o[k] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", k, err_o[k]); end
            total++; if (os_o[k] !== 3'd0) begin bad++; $display("FAIL reset_outstanding[%0d]: got %0d want 0", k, os_o[k]); end
        end
        stall[0] = 1'b1;
        #1;
        total++; if (gnt_o[0] !== 1'b0) begin bad++; $display("FAIL reset_gnt_stalled: got %b want 0", gnt_o[0]); end
        stall[0] = 1'b0;
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        next();
        rst = 1'b0;
    endtask

    // Write DEADBEEF to 0x10, read it back on the next cycle.
    task automatic test_read_after_write();
        drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        total++; if (gnt_o[0] !== 1'b1) begin bad++; $display("FAIL raw_wr_gnt: got %b want 1", gnt_o[0]); end
        total++; if (rv_o[0] !== 1'b0) begin bad++; $display("FAIL raw_idle_rvalid: got %b want 0", rv_o[0]); end
        next();
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (gnt_o[0] !== 1'b1) begin bad++; $display("FAIL raw_rd_gnt: got %b want 1", gnt_o[0]); end
        total++; if ({rv_o[0], err_o[0], rd_o[0]} !== {1'b1, 1'b0, 32'h0})
            begin bad++; $display("FAIL raw_wr_resp: got rv=%b err=%b rd=%h want rv=1 err=0 rd=0", rv_o[0], err_o[0], rd_o[0]); end
        total++; if (os_o[0] !== 3'd1) begin bad++; $display("FAIL raw_outstanding: got %0d want 1", os_o[0]); end
        next();
        req[0] = 1'b0;
        @(negedge clk);
        total++; if ({rv_o[0], err_o[0], rd_o[0]} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
            begin bad++; $display("FAIL raw_rd_resp: got rv=%b err=%b rd=%h want rv=1 err=0 rd=deadbeef", rv_o[0], err_o[0], rd_o[0]); end
        next();
        @(negedge clk);
        total++; if ({rv_o[0], rd_o[0], os_o[0]} !== {1'b1 ^ 1'b1, 32'h0, 3'd0})
            begin bad++; $display("FAIL raw_quiet: got rv=%b rd=%h os=%0d want 0 0 0", rv_o[0], rd_o[0], os_o[0]); end
        next();
    endtask

    // Clear 0x20, write 11223344 with be=0110, read back.
    task automatic test_byte_enables();
        drive(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h0);
        next();
        drive(0, 1'b1, 1'b1, 32'h20, 4'b0110, 32'h1122_3344);
        @(negedge clk);
        total++; if (gnt_o[0] !== 1'b1) begin bad++; $display("FAIL be_wr_gnt: got %b want 1", gnt_o[0]); end
        next();
        drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        next();
        req[0] = 1'b0;
        @(negedge clk);
        total++; if ({rv_o[0], rd_o[0]} !== {1'b1, 32'h0022_3300})
            begin bad++; $display("FAIL be_rd_resp: got rv=%b rd=%h want rv=1 rd=00223300", rv_o[0], rd_o[0]); end
        next();
    endtask

    // One request per cycle; each response arrives on the following cycle.
    task automatic test_out_of_range();
        logic        v_we  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] v_ad  [7] = '{32'h0, 32'hFFC, 32'h1000, 32'h1000, 32'hFFFF_FFFC, 32'h0, 32'hFFF};
        logic [31:0] v_wd  [7] = '{32'h5A5A_A5A5, 32'h0BAD_F00D, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        logic        v_err [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] v_rd  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5A5A_A5A5, 32'h0BAD_F00D};
        for (int i = 0; i < 8; i++) begin
            if (i < 7) drive(0, 1'b1, v_we[i], v_ad[i], 4'hF, v_wd[i]);
            else       req[0] = 1'b0;
            @(negedge clk);
            if (i < 7) begin
                total++; if (gnt_o[0] !== 1'b1) begin bad++; $display("FAIL oor_gnt[%0d]: got %b want 1", i, gnt_o[0]); end
            end
            if (i == 0) begin
                total++; if (rv_o[0] !== 1'b0) begin bad++; $display("FAIL oor_rvalid0: got %b want 0", rv_o[0]); end
            end else begin
                total++;
                if ({rv_o[0], err_o[0], rd_o[0]} !== {1'b1, v_err[i-1], v_rd[i-1]}) begin
                    bad++;
                    $display("FAIL oor_resp[%0d]: got rv=%b err=%b rd=%h want rv=1 err=%b rd=%h",
                             i - 1, rv_o[0], err_o[0], rd_o[0], v_err[i-1], v_rd[i-1]);
                end
            end
            next();
        end
    endtask

    // Sustained one grant and one response per cycle at Latency 1.
    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(0, 1'b1, 1'b0, (i % 2 == 0) ? 32'h10 : 32'h20, 4'h0, 32'h0);
            else       req[0] = 1'b0;
            @(negedge clk);
            if (i < 8) begin
                total++; if (gnt_o[0] !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, gnt_o[0]); end
            end
            if (i > 0) begin
                exp = (i % 2 == 1) ? 32'hDEAD_BEEF : 32'h0022_3300;
                total++;
                if ({rv_o[0], rd_o[0], os_o[0]} !== {1'b1, exp, 3'd1}) begin
                    bad++;
                    $display("FAIL b2b_resp[%0d]: got rv=%b rd=%h os=%0d want rv=1 rd=%h os=1", i, rv_o[0], rd_o[0], os_o[0], exp);
                end
            end
            next();
        end
    endtask

    // Latency 4, depth 2, request held high.
    task automatic test_outstanding_limit();
        logic        c_req [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        logic [31:0] c_ad  [11] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h48, 32'h48, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        c_gnt [11] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic        c_rv  [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
        logic [31:0] c_rd  [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA0A0_0040, 32'hA0A0_0044,
                                    32'h0, 32'h0, 32'h0, 32'hA0A0_0048, 32'h0};
        logic [2:0]  c_os  [11] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        do_write(1, 32'h40, 32'hA0A0_0040);
        do_write(1, 32'h44, 32'hA0A0_0044);
        do_write(1, 32'h48, 32'hA0A0_0048);
        drain(1);
        for (int c = 0; c < 11; c++) begin
            drive(1, c_req[c], 1'b0, c_ad[c], 4'h0, 32'h0);
            @(negedge clk);
            total++;
            if ({gnt_o[1], rv_o[1], rd_o[1], os_o[1]} !== {c_gnt[c], c_rv[c], c_rd[c], c_os[c]}) begin
                bad++;
                $display("FAIL limit_cycle[%0d]: got gnt=%b rv=%b rd=%h os=%0d want gnt=%b rv=%b rd=%h os=%0d",
                         c, gnt_o[1], rv_o[1], rd_o[1], os_o[1], c_gnt[c], c_rv[c], c_rd[c], c_os[c]);
            end
            next();
        end
    endtask

    // Stall blocks the grant; reset discards an in-flight read.
    task automatic test_stall_reset();
        do_write(2, 32'h80, 32'hC0DE_0080);
        drain(2);
        drive(2, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0);
        stall[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (gnt_o[2] !== 1'b0) begin bad++; $display("FAIL stall_gnt[%0d]: got %b want 0", c, gnt_o[2]); end
            next();
        end
        stall[2] = 1'b0;
        @(negedge clk);
        total++; if (gnt_o[2] !== 1'b1) begin bad++; $display("FAIL unstall_gnt: got %b want 1", gnt_o[2]); end
        next();
        req[2] = 1'b0;
        total++; if (os_o[2] !== 3'd1) begin bad++; $display("FAIL pre_reset_outstanding: got %0d want 1", os_o[2]); end
        rst = 1'b1;
        #1;
        total++; if ({rv_o[2], os_o[2]} !== {1'b0, 3'd0})
            begin bad++; $display("FAIL in_reset: got rv=%b os=%0d want rv=0 os=0", rv_o[2], os_o[2]); end
        next();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if ({rv_o[2], os_o[2]} !== {1'b0, 3'd0})
                begin bad++; $display("FAIL post_reset_quiet[%0d]: got rv=%b os=%0d want rv=0 os=0", c, rv_o[2], os_o[2]); end
            next();
        end
        drive(2, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (gnt_o[2] !== 1'b1) begin bad++; $display("FAIL post_reset_gnt: got %b want 1", gnt_o[2]); end
        next();
        req[2] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (c == 3) begin
                if ({rv_o[2], err_o[2], rd_o[2]} !== {1'b1, 1'b0, 32'hC0DE_0080}) begin
                    bad++; $display("FAIL post_reset_resp: got rv=%b err=%b rd=%h want rv=1 err=0 rd=c0de0080", rv_o[2], err_o[2], rd_o[2]);
                end
            end else if (rv_o[2] !== 1'b0) begin
                bad++; $display("FAIL post_reset_rvalid[+%0d]: got %b want 0", c, rv_o[2]);
            end
            next();
        end
        total++; if (os_o[2] !== 3'd0) begin bad++; $display("FAIL post_reset_final_os: got %0d want 0", os_o[2]); end
    endtask

    initial begin
        test_reset();
        test_read_after_write();
        test_byte_enables();
        test_out_of_range();
        test_back_to_back();
        test_outstanding_limit();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
